// File: rtl/ifu_ibuf_pkg.sv
// Shared core constants and the instruction-buffer entry layout.
`timescale 1ns / 1ps
package ifu_ibuf_pkg;

    localparam int unsigned ILEN    = 32;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned IBUF_EW = 65;

    localparam logic [1:0] RV32_LEN = 2'b11;

    typedef struct packed {
        logic            ilgl;
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] in;
    } ibuf_entry_t;

    // Any low-bit pattern other than 2'b11 marks a compressed or non-RV32 encoding.
    function automatic logic is_ilgl(input logic [ILEN-1:0] ins);
        return ins[1:0] != RV32_LEN;
    endfunction

endpackage

// File: rtl/ibuf_fifo.sv
// Generic circular FIFO with async-reset pointers, occupancy count and synchronous clear.
`timescale 1ns / 1ps
module ibuf_fifo #(
    parameter int unsigned Width = 65,
    parameter int unsigned Depth = 2,
    parameter int unsigned Aw    = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic [Aw:0]      cnt_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [Aw:0] FullCnt = (Aw + 1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [Aw-1:0]    wp_q;
    logic [Aw-1:0]    rp_q;
    logic [Aw:0]      cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr_i) begin
            // Storage is intentionally left intact; only the pointers are reset.
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wp_q] <= wdata_i;
                wp_q        <= wp_q + 1'b1;
            end
            if (pop_i) begin
                rp_q <= rp_q + 1'b1;
            end
            if (push_i && !pop_i) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop_i && !push_i) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign rdata_o = mem_q[rp_q];
    assign cnt_o   = cnt_q;
    assign full_o  = (cnt_q == FullCnt);
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/ifu_ibuf.sv
// Fetch-to-decode instruction buffer with flush masking and illegal-encoding marker.
// Optional zero-latency bypass when empty is enabled by defining IFU_IBUF_BYPASS_EN.
`timescale 1ns / 1ps
module ifu_ibuf
    import ifu_ibuf_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_val,
    output logic            o_rdy,
    input  logic [ILEN-1:0] i_in,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_flush,
    output logic            o_val,
    input  logic            i_rdy,
    output logic [ILEN-1:0] o_in,
    output logic [XLEN-1:0] o_pc,
    output logic            o_ilgl,
    output logic [AW:0]     o_cnt
);

    ibuf_entry_t wr_entry;
    ibuf_entry_t rd_entry;
    ibuf_entry_t head;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;

    assign wr_entry = '{ilgl: is_ilgl(i_in), pc: i_pc, in: i_in};

    // Only a non-empty buffer can be popped; flush discards both sides.
    assign pop   = ~empty & i_rdy & ~i_flush;
    assign o_rdy = ~full;

`ifdef IFU_IBUF_BYPASS_EN
    logic byp;
    assign byp   = empty & i_val & ~i_flush;
    assign o_val = (~empty | i_val) & ~i_flush;
    assign head  = byp ? wr_entry : rd_entry;
    // A bypassed entry taken by decode this cycle never gets written.
    assign push  = i_val & ~full & ~i_flush & ~(byp & i_rdy);
`else
    assign o_val = ~empty & ~i_flush;
    assign head  = rd_entry;
    assign push  = i_val & ~full & ~i_flush;
`endif

    ibuf_fifo #(
        .Width (IBUF_EW),
        .Depth (DEPTH),
        .Aw    (AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (i_flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_entry),
        .rdata_o (rd_entry),
        .cnt_o   (o_cnt),
        .full_o  (full),
        .empty_o (empty)
    );

    assign o_in   = head.in;
    assign o_pc   = head.pc;
    assign o_ilgl = head.ilgl;

endmodule

// File: tb/tb_ifu_ibuf.sv
// Directed self-checking bench for ifu_ibuf (DEPTH=2), checks via immediate assertions.
`timescale 1ns / 1ps
module tb_ifu_ibuf;

    logic        clk;
    logic        rst_n;
    logic        i_val;
    logic        o_rdy;
    logic [31:0] i_in;
    logic [31:0] i_pc;
    logic        i_flush;
    logic        o_val;
    logic        i_rdy;
    logic [31:0] o_in;
    logic [31:0] o_pc;
    logic        o_ilgl;
    logic [1:0]  o_cnt;

    int total = 0;
    int fails = 0;

    ifu_ibuf #(
        .DEPTH (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_val   (i_val),
        .o_rdy   (o_rdy),
        .i_in    (i_in),
        .i_pc    (i_pc),
        .i_flush (i_flush),
        .o_val   (o_val),
        .i_rdy   (i_rdy),
        .o_in    (o_in),
        .o_pc    (o_pc),
        .o_ilgl  (o_ilgl),
        .o_cnt   (o_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        i_val   = 1'b0;
        i_in    = '0;
        i_pc    = '0;
        i_flush = 1'b0;
        i_rdy   = 1'b0;
        #3;
        chk("rst_oval", 32'(o_val), 32'd0);
        chk("rst_ordy", 32'(o_rdy), 32'd1);
        chk("rst_cnt", 32'(o_cnt), 32'd0);
        chk("rst_oin", o_in, 32'd0);
        chk("rst_opc", o_pc, 32'd0);
        chk("rst_ilgl", 32'(o_ilgl), 32'd0);
        #9;
        rst_n = 1'b1;
        tick();

        // First push: visible one cycle later
        i_val = 1'b1; i_in = 32'h0000_0013; i_pc = 32'd0;
        #1;
        chk("push0_same_cycle_oval", 32'(o_val), 32'd0);
        tick();
        i_val = 1'b0;
        #1;
        chk("push0_oval", 32'(o_val), 32'd1);
        chk("push0_oin", o_in, 32'h0000_0013);
        chk("push0_opc", o_pc, 32'd0);
        chk("push0_ilgl", 32'(o_ilgl), 32'd0);
        chk("push0_cnt", 32'(o_cnt), 32'd1);
        i_rdy = 1'b1;
        tick();
        i_rdy = 1'b0;
        #1;
        chk("pop0_cnt", 32'(o_cnt), 32'd0);
        chk("pop0_oval", 32'(o_val), 32'd0);

        // Fill with decode stalled, then backpressure
        i_val = 1'b1; i_in = 32'h0000_0013; i_pc = 32'd0;
        tick();
        i_in = 32'h0010_0093; i_pc = 32'd4;
        tick();
        i_pc = 32'd8;
        #1;
        chk("full_ordy", 32'(o_rdy), 32'd0);
        chk("full_cnt", 32'(o_cnt), 32'd2);
        chk("full_head", o_pc, 32'd0);
        tick();
        chk("full_hold_cnt", 32'(o_cnt), 32'd2);
        i_rdy = 1'b1;
        tick();
        i_rdy = 1'b0;
        #1;
        chk("full_pop_cnt", 32'(o_cnt), 32'd1);
        chk("full_pop_ordy", 32'(o_rdy), 32'd1);
        chk("full_pop_head", o_pc, 32'd4);
        tick();
        i_val = 1'b0;
        #1;
        chk("late_push_cnt", 32'(o_cnt), 32'd2);
        i_rdy = 1'b1;
        #1;
        chk("drain_pc4", o_pc, 32'd4);
        tick();
        chk("drain_pc8", o_pc, 32'd8);
        tick();
        chk("drain_cnt", 32'(o_cnt), 32'd0);
        i_rdy = 1'b0;

        // Steady streaming across several pointer wraps
        i_val = 1'b1; i_rdy = 1'b1; i_in = 32'h0000_0013;
        for (int k = 0; k < 10; k++) begin
            i_pc = 32'(4 * k);
            #1;
            if (k == 0) begin
                chk("stream_empty_oval", 32'(o_val), 32'd0);
            end else begin
                chk($sformatf("stream_pc%0d", k), o_pc, 32'(4 * (k - 1)));
                chk($sformatf("stream_cnt%0d", k), 32'(o_cnt), 32'd1);
            end
            tick();
        end
        i_val = 1'b0;
        #1;
        chk("stream_last_pc", o_pc, 32'd36);
        chk("stream_last_val", 32'(o_val), 32'd1);
        tick();
        chk("stream_end_cnt", 32'(o_cnt), 32'd0);
        i_rdy = 1'b0;

        // Flush while full, held two cycles with a live push
        i_val = 1'b1; i_pc = 32'd200;
        tick();
        i_pc = 32'd204;
        tick();
        i_pc = 32'd100; i_flush = 1'b1; i_rdy = 1'b1;
        #1;
        chk("flush_oval", 32'(o_val), 32'd0);
        chk("flush_cnt_before", 32'(o_cnt), 32'd2);
        tick();
        chk("flush_cnt_after", 32'(o_cnt), 32'd0);
        chk("flush_held_oval", 32'(o_val), 32'd0);
        tick();
        chk("flush_held_cnt", 32'(o_cnt), 32'd0);
        i_flush = 1'b0; i_val = 1'b0; i_rdy = 1'b0;
        #1;
        chk("post_flush_oval", 32'(o_val), 32'd0);
        chk("post_flush_ordy", 32'(o_rdy), 32'd1);

        // Illegal encoding marker
        i_val = 1'b1; i_in = 32'h0000_4501; i_pc = 32'h44;
        tick();
        i_val = 1'b0;
        #1;
        chk("ilgl_flag", 32'(o_ilgl), 32'd1);
        chk("ilgl_oin", o_in, 32'h0000_4501);
        chk("ilgl_opc", o_pc, 32'h44);
        chk("ilgl_cnt", 32'(o_cnt), 32'd1);
        i_rdy = 1'b1;
        tick();
        i_rdy = 1'b0;
        chk("ilgl_pop_cnt", 32'(o_cnt), 32'd0);

        // Empty buffer with fetch and decode both ready
        i_val = 1'b1; i_rdy = 1'b1; i_in = 32'h0000_0013; i_pc = 32'h40;
        #1;
`ifdef IFU_IBUF_BYPASS_EN
        chk("byp_oval", 32'(o_val), 32'd1);
        chk("byp_opc", o_pc, 32'h40);
        chk("byp_ilgl", 32'(o_ilgl), 32'd0);
        tick();
        i_val = 1'b0; i_rdy = 1'b0;
        #1;
        chk("byp_cnt", 32'(o_cnt), 32'd0);
`else
        chk("nobyp_oval", 32'(o_val), 32'd0);
        tick();
        i_val = 1'b0; i_rdy = 1'b0;
        #1;
        chk("nobyp_cnt", 32'(o_cnt), 32'd1);
        chk("nobyp_opc", o_pc, 32'h40);
`endif
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;

        // Asynchronous reset mid-operation
        i_val = 1'b1; i_pc = 32'h80;
        tick();
        i_pc = 32'h84;
        tick();
        i_val = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_oval", 32'(o_val), 32'd0);
        chk("arst_cnt", 32'(o_cnt), 32'd0);
        chk("arst_ordy", 32'(o_rdy), 32'd1);
        chk("arst_opc", o_pc, 32'd0);
        chk("arst_oin", o_in, 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        i_val = 1'b1; i_in = 32'h0000_0013; i_pc = 32'h88;
        tick();
        i_val = 1'b0;
        #1;
        chk("arst_first_push_pc", o_pc, 32'h88);
        chk("arst_first_push_val", 32'(o_val), 32'd1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
